// File: rtl/echo_delay_ctrl.sv
// echo_delay_ctrl
// ---------------
// Sequencer for an echo effect in front of a dual-port delay memory.
// After reset the whole circular buffer (T words) is zero-filled. After that,
// each accepted sample goes through four steps:
//   1. The word written DELAY positions earlier is read back.
//   2. That word is attenuated by an arithmetic right shift of FB_SHIFT
//      (FB_SHIFT = 0 mutes the echo).
//   3. The attenuated echo is added to the input sample.
//   4. The sum is written back at wr_ptr and presented downstream.
//
// Build option:
//   ECHO_SAT_EN  defined   -> the sum saturates on signed overflow
//                undefined -> the sum wraps modulo 2^32
//
// Parameters:
//   B        address width of the delay memory
//   T        buffer depth in words (T <= 2^B)
//   MEM_LAT  cycles from ADDR1 driven to DO1 valid
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   IN_DATA/VALID/READY input sample handshake (signed 32-bit)
//   DELAY, FB_SHIFT     echo distance and feedback attenuation, sampled on accept
//   OUT_DATA/OUT_VALID  mixed sample, one-cycle valid pulse, data held between pulses
//   WE, ADDR2, DI       memory write port (ADDR2 tracks wr_ptr outside CLEAR)
//   ADDR1, DO1          memory read port
module echo_delay_ctrl #(
    parameter int B       = 15,
    parameter int T       = 20000,
    parameter int MEM_LAT = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [31:0]   IN_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [B-1:0]  DELAY,
    input  logic [2:0]    FB_SHIFT,
    output logic [31:0]   OUT_DATA,
    output logic          OUT_VALID,
    output logic          WE,
    output logic [B-1:0]  ADDR1,
    output logic [B-1:0]  ADDR2,
    output logic [31:0]   DI,
    input  logic [31:0]   DO1
);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_MIX   = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    localparam logic [B:0]   DEPTH_W   = (B+1)'(T);
    localparam logic [B-1:0] LAST_W    = B'(T - 1);
    localparam logic [B-1:0] ONE_W     = B'(1);
    // Final WAIT count; only meaningful when MEM_LAT >= 2.
    localparam logic [7:0]   WAIT_LAST = 8'(MEM_LAT - 2);

    // Reduce the 33-bit sum of sample and echo to 32 bits.
    function automatic logic [31:0] mix_sum(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
`ifdef ECHO_SAT_EN
        // Sign bits disagree exactly when the 32-bit result overflowed.
        if (s[32] != s[31]) begin
            mix_sum = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            mix_sum = 32'(s);
        end
`else
        mix_sum = 32'(s);
`endif
    endfunction

    state_t        state_r, state_s;
    logic [B:0]    clr_cnt_r, clr_cnt_s;
    logic [7:0]    wait_cnt_r, wait_cnt_s;
    logic [B-1:0]  wr_ptr_r, wr_ptr_s;
    logic [31:0]   in_r, in_s;
    logic [2:0]    fb_r, fb_s;
    logic          in_ready_r, in_ready_s;
    logic          out_valid_r, out_valid_s;
    logic [31:0]   out_data_r, out_data_s;
    logic          we_r, we_s;
    logic [B-1:0]  addr1_r, addr1_s;
    logic [B-1:0]  addr2_r, addr2_s;
    logic [31:0]   di_r, di_s;

    logic [B-1:0]  dly_s;
    logic [B-1:0]  rd_addr_s;
    logic [B-1:0]  wr_ptr_inc_s;
    logic [31:0]   echo_s;
    logic [31:0]   sum_s;

    // Clamp the live DELAY input into 1..T-1.
    always_comb begin
        dly_s = DELAY;
        if (DELAY == '0) begin
            dly_s = ONE_W;
        end else if ({1'b0, DELAY} >= DEPTH_W) begin
            dly_s = LAST_W;
        end else begin
            dly_s = DELAY;
        end
    end

    // Circular read address wr_ptr - d, folded back into 0..T-1.
    always_comb begin
        rd_addr_s = '0;
        if (wr_ptr_r >= dly_s) begin
            rd_addr_s = wr_ptr_r - dly_s;
        end else begin
            rd_addr_s = B'({1'b0, wr_ptr_r} + DEPTH_W - {1'b0, dly_s});
        end
    end

    // Write pointer advance with wrap T-1 -> 0.
    always_comb begin
        wr_ptr_inc_s = '0;
        if (wr_ptr_r == LAST_W) begin
            wr_ptr_inc_s = '0;
        end else begin
            wr_ptr_inc_s = wr_ptr_r + ONE_W;
        end
    end

    // Echo term and mixed sum, consumed in MIX.
    always_comb begin
        echo_s = 32'd0;
        if (fb_r == 3'd0) begin
            echo_s = 32'd0;
        end else begin
            echo_s = 32'($signed(DO1) >>> fb_r);
        end
        sum_s = mix_sum(in_r, echo_s);
    end

    // Next state plus next value of every registered output. Each output
    // register therefore always reflects the state that is current in the
    // same cycle.
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        wr_ptr_s    = wr_ptr_r;
        in_s        = in_r;
        fb_s        = fb_r;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_data_s  = out_data_r;
        we_s        = 1'b0;
        addr1_s     = addr1_r;
        addr2_s     = wr_ptr_r;
        di_s        = 32'd0;
        case (state_r)
            S_CLEAR: begin
                // Counter runs 0..T. The value T marks the cycle after the
                // last zero-fill write.
                if (clr_cnt_r == DEPTH_W) begin
                    state_s    = S_IDLE;
                    clr_cnt_s  = '0;
                    wr_ptr_s   = '0;
                    addr2_s    = '0;
                    in_ready_s = 1'b1;
                end else begin
                    we_s      = 1'b1;
                    addr2_s   = clr_cnt_r[B-1:0];
                    clr_cnt_s = clr_cnt_r + (B+1)'(1);
                end
            end
            S_IDLE: begin
                // The read address is resolved here from the clamped delay.
                // Later DELAY changes cannot disturb the sample in flight.
                if (IN_VALID && in_ready_r) begin
                    state_s = S_READ;
                    in_s    = IN_DATA;
                    fb_s    = FB_SHIFT;
                    addr1_s = rd_addr_s;
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            S_READ: begin
                if (MEM_LAT <= 1) begin
                    state_s = S_MIX;
                end else begin
                    state_s    = S_WAIT;
                    wait_cnt_s = 8'd0;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = S_MIX;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            S_MIX: begin
                state_s     = S_WRITE;
                we_s        = 1'b1;
                di_s        = sum_s;
                out_data_s  = sum_s;
                out_valid_s = 1'b1;
            end
            S_WRITE: begin
                state_s    = S_IDLE;
                wr_ptr_s   = wr_ptr_inc_s;
                addr2_s    = wr_ptr_inc_s;
                in_ready_s = 1'b1;
            end
            default: begin
                state_s   = S_CLEAR;
                clr_cnt_s = '0;
                wr_ptr_s  = '0;
                addr2_s   = '0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= S_CLEAR;
            clr_cnt_r   <= '0;
            wait_cnt_r  <= 8'd0;
            wr_ptr_r    <= '0;
            in_r        <= 32'd0;
            fb_r        <= 3'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            we_r        <= 1'b0;
            addr1_r     <= '0;
            addr2_r     <= '0;
            di_r        <= 32'd0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= clr_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
            wr_ptr_r    <= wr_ptr_s;
            in_r        <= in_s;
            fb_r        <= fb_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            we_r        <= we_s;
            addr1_r     <= addr1_s;
            addr2_r     <= addr2_s;
            di_r        <= di_s;
        end
    end

    assign IN_READY  = in_ready_r;
    assign OUT_VALID = out_valid_r;
    assign OUT_DATA  = out_data_r;
    assign WE        = we_r;
    assign ADDR1     = addr1_r;
    assign ADDR2     = addr2_r;
    assign DI        = di_r;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl.
// Configuration: T=16, MEM_LAT=2, B=6, so that DELAY=40 is representable.
// The memory model is a behavioural dual-port RAM with a 2-cycle read latency.
module tb_echo_delay_ctrl;

    localparam int B = 6;
    localparam int T = 16;
    localparam int MEM_LAT = 2;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [31:0]   IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [B-1:0]  DELAY;
    logic [2:0]    FB_SHIFT;
    logic [31:0]   OUT_DATA;
    logic          OUT_VALID;
    logic          WE;
    logic [B-1:0]  ADDR1;
    logic [B-1:0]  ADDR2;
    logic [31:0]   DI;
    logic [31:0]   DO1;

    logic [31:0]   mem [0:(1<<B)-1];
    logic [31:0]   rd_pipe;

    int tests = 0;
    int fails = 0;

    echo_delay_ctrl #(.B(B), .T(T), .MEM_LAT(MEM_LAT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DELAY(DELAY), .FB_SHIFT(FB_SHIFT),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .WE(WE), .ADDR1(ADDR1), .ADDR2(ADDR2), .DI(DI), .DO1(DO1)
    );

    always #5 CLK = ~CLK;

    // Memory model: the write port is registered, and the read port has a
    // two-stage read pipeline.
    always @(posedge CLK) begin
        if (WE) mem[ADDR2] <= DI;
        rd_pipe <= mem[ADDR1];
        DO1     <= rd_pipe;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one sample through the DUT.
    // exp_rd is the read address expected on ADDR1, exp_wr the wr_ptr
    // expected on ADDR2 during WRITE, and exp_out the expected mixed sample.
    task automatic send(input logic [31:0] data, input logic [B-1:0] dly, input logic [2:0] fb,
                        input logic [B-1:0] exp_rd, input logic [B-1:0] exp_wr,
                        input logic [31:0] exp_out);
        int n;
        n = 0;
        while (IN_READY !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b1;
        IN_DATA  = data;
        DELAY    = dly;
        FB_SHIFT = fb;
        tick();
        // Scramble the controls after accept; the sample in flight must not care.
        IN_VALID = 1'b0;
        IN_DATA  = 32'hDEAD_BEEF;
        DELAY    = 6'd7;
        FB_SHIFT = 3'd7;
        check("addr1", {26'd0, ADDR1}, {26'd0, exp_rd});
        check("ready_low", {31'd0, IN_READY}, 32'd0);
        n = 1;
        while (OUT_VALID !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        check("out_latency", n, 32'd4);
        check("out_data", OUT_DATA, exp_out);
        check("di", DI, exp_out);
        check("we_write", {31'd0, WE}, 32'd1);
        check("addr2_write", {26'd0, ADDR2}, {26'd0, exp_wr});
        tick();
        check("valid_pulse_end", {31'd0, OUT_VALID}, 32'd0);
        check("ready_back", {31'd0, IN_READY}, 32'd1);
        check("we_idle", {31'd0, WE}, 32'd0);
        check("out_hold", OUT_DATA, exp_out);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, IN_READY}, 32'd0);
        check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
        check({tag, "_out"}, OUT_DATA, 32'd0);
        check({tag, "_we"}, {31'd0, WE}, 32'd0);
        check({tag, "_addr1"}, {26'd0, ADDR1}, 32'd0);
        check({tag, "_addr2"}, {26'd0, ADDR2}, 32'd0);
        check({tag, "_di"}, DI, 32'd0);
    endtask

    logic [31:0] exp_v;
    logic [31:0] ovf_exp;

    initial begin
        RST_N    = 1'b0;
        IN_DATA  = 32'd0;
        IN_VALID = 1'b0;
        DELAY    = 6'd0;
        FB_SHIFT = 3'd0;
`ifdef ECHO_SAT_EN
        ovf_exp = 32'h7FFF_FFFF;
`else
        ovf_exp = 32'hBFFF_FFE8;
`endif
        tick();
        tick();
        check_reset_outputs("rst");

        // Zero-fill: 16 writes. A request offered during CLEAR must be ignored.
        RST_N    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 32'h1111_1111;
        for (int i = 0; i < T; i++) begin
            tick();
            check("clr_we", {31'd0, WE}, 32'd1);
            check("clr_addr2", {26'd0, ADDR2}, i);
            check("clr_di", DI, 32'd0);
            check("clr_ready", {31'd0, IN_READY}, 32'd0);
            check("clr_valid", {31'd0, OUT_VALID}, 32'd0);
            check("clr_out", OUT_DATA, 32'd0);
        end
        IN_VALID = 1'b0;
        tick();
        check("clr_done_ready", {31'd0, IN_READY}, 32'd1);
        check("clr_done_we", {31'd0, WE}, 32'd0);
        check("clr_done_addr2", {26'd0, ADDR2}, 32'd0);

        // Impulse: DELAY=4, FB_SHIFT=1 -> 1000,0,0,0,500,0,0,0,250.
        for (int i = 0; i < 9; i++) begin
            exp_v = (i == 0) ? 32'd1000 : (i == 4) ? 32'd500 : (i == 8) ? 32'd250 : 32'd0;
            send((i == 0) ? 32'd1000 : 32'd0, 6'd4, 3'd1, 6'((i + 12) % 16), 6'(i), exp_v);
        end

        // Wrap-around: DELAY=3, wr_ptr runs 9..15,0..12; wr_ptr=1 reads 14.
        for (int i = 0; i < 20; i++) begin
            send(32'(100 + i), 6'd3, 3'd0, 6'(((9 + i) % 16 + 13) % 16), 6'((9 + i) % 16),
                 32'(100 + i));
        end

        // Clamp: DELAY=0 acts as 1, DELAY=40 acts as 15.
        send(32'd5, 6'd0, 3'd0, 6'd12, 6'd13, 32'd5);
        send(32'd6, 6'd40, 3'd0, 6'd15, 6'd14, 32'd6);
        // mem[0] holds 107 from the wrap pass: 107 >>> 1 = 53.
        send(32'd0, 6'd40, 3'd1, 6'd0, 6'd15, 32'd53);

        // Negative echo: -100 >>> 3 = -13.
        send(32'hFFFF_FF9C, 6'd1, 3'd0, 6'd15, 6'd0, 32'hFFFF_FF9C);
        send(32'd0, 6'd1, 3'd3, 6'd0, 6'd1, 32'hFFFF_FFF3);

        // Overflow: 7FFFFFF0 + (7FFFFFF0 >>> 1).
        send(32'h7FFF_FFF0, 6'd1, 3'd0, 6'd1, 6'd2, 32'h7FFF_FFF0);
        send(32'h7FFF_FFF0, 6'd1, 3'd1, 6'd2, 6'd3, ovf_exp);

        // Reset asserted during WAIT.
        IN_VALID = 1'b1;
        IN_DATA  = 32'd1234;
        DELAY    = 6'd1;
        FB_SHIFT = 3'd1;
        tick();                                  // READ
        IN_VALID = 1'b0;
        check("abort_addr1_pre", {26'd0, ADDR1}, 32'd3);
        tick();                                  // WAIT
        RST_N = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_pulse", {31'd0, OUT_VALID}, 32'd0);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reclr_we", {31'd0, WE}, 32'd1);
            check("reclr_addr2", {26'd0, ADDR2}, i);
            check("reclr_valid", {31'd0, OUT_VALID}, 32'd0);
            check("reclr_out", OUT_DATA, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
